// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a valid/ready request-response handshake.
// One access is in flight at a time; each response appears WAIT_CYCLES+1 cycles after acceptance.
module data_mem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           we_q;
    logic           fault_q;
    logic [AW-1:0]  idx_q;
    logic [31:0]    resp_rdata_q, resp_rdata_d;
    logic           resp_err_q, resp_err_d;

    logic [31:0]    mem [DEPTH];

    logic           accept;
    logic           req_fault;
    logic [AW-1:0]  req_idx;
    logic           enter_resp;
    logic           ld_we;
    logic           ld_fault;
    logic [AW-1:0]  rd_idx;

    assign accept    = req_valid && (state_q == S_IDLE);
    assign req_fault = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
    assign req_idx   = req_addr[AW+1:2];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_rdata = resp_rdata_q;
        resp_err   = resp_err_q;
    end

    // With zero wait cycles RESP is entered on the accept edge itself, so the
    // response must come from the live request rather than the captured one.
    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
    assign ld_we      = (state_q == S_IDLE) ? req_we    : we_q;
    assign ld_fault   = (state_q == S_IDLE) ? req_fault : fault_q;
    assign rd_idx     = (state_q == S_IDLE) ? req_idx   : idx_q;

    always_comb begin
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        if (enter_resp) begin
            resp_rdata_d = (!ld_we && !ld_fault) ? mem[rd_idx] : 32'd0;
            resp_err_d   = ld_fault;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q         <= 1'b0;
            fault_q      <= 1'b0;
            idx_q        <= '0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                fault_q <= req_fault;
                idx_q   <= req_idx;
            end
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Memory has no reset so stored data survives a reset pulse.
    always_ff @(posedge clk) begin
        if (!rst && accept && req_we && !req_fault) begin
            mem[req_idx] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table, random traffic against an array model,
// hand sequences for back-pressure, ignored strobes, reset mid-access and zero-wait throughput.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        req_valid0, req_we0, resp_ready0;
    logic [31:0] req_addr0, req_wdata0;
    logic        req_ready0, resp_valid0, resp_err0;
    logic [31:0] resp_rdata0;

    int total = 0;
    int bad   = 0;
    logic [31:0] ref_mem [64];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_ready(req_ready0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic model_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'd64);
    endfunction

    function automatic logic [31:0] model_rdata(input logic we, input logic [31:0] a);
        logic [5:0] w;
        w = a[7:2];
        if (we || model_fault(a)) return 32'd0;
        return ref_mem[w];
    endfunction

    // One complete access on the WAIT_CYCLES=2 instance, with resp_ready held low for `hold` extra cycles.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input int hold, input logic [31:0] er, input logic ee, input string tag);
        int lat;
        logic [5:0] w;
        w = addr[7:2];
        if (we && !model_fault(addr)) ref_mem[w] = wdata;
        @(negedge clk);
        chk({tag, " req_ready idle"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; resp_ready = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
        end while (!resp_valid && lat < 50);
        chk({tag, " latency"}, 32'(lat), 32'd3);
        chk({tag, " rdata"}, resp_rdata, er);
        chk({tag, " err"}, {31'd0, resp_err}, {31'd0, ee});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold valid"}, {31'd0, resp_valid}, 32'd1);
            chk({tag, " hold ready"}, {31'd0, req_ready}, 32'd0);
            chk({tag, " hold rdata"}, resp_rdata, er);
            chk({tag, " hold err"}, {31'd0, resp_err}, {31'd0, ee});
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, " done valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, " kept rdata"}, resp_rdata, er);
        chk({tag, " kept err"}, {31'd0, resp_err}, {31'd0, ee});
        $display("txn %s we=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d hold=%0d",
                 tag, we, addr, wdata, resp_rdata, resp_err, lat, hold);
    endtask

    task automatic model_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input int hold, input string tag);
        txn(we, addr, wdata, hold, model_rdata(we, addr), model_fault(addr), tag);
    endtask

    initial begin
        int lat;
        logic [31:0] a, d, er;

        tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 0, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h10,       32'h0,        5, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b0, 32'h13,       32'h0,        0, 32'h0,        1'b1};
        tbl[3]  = '{1'b0, 32'h100,      32'h0,        1, 32'h0,        1'b1};
        tbl[4]  = '{1'b1, 32'h100,      32'hCAFEF00D, 0, 32'h0,        1'b1};
        tbl[5]  = '{1'b0, 32'h10,       32'h0,        2, 32'hDEADBEEF, 1'b0};
        tbl[6]  = '{1'b1, 32'hFC,       32'h12345678, 0, 32'h0,        1'b0};
        tbl[7]  = '{1'b0, 32'hFC,       32'h0,        0, 32'h12345678, 1'b0};
        tbl[8]  = '{1'b0, 32'hFE,       32'h0,        0, 32'h0,        1'b1};
        tbl[9]  = '{1'b1, 32'h11,       32'hFFFFFFFF, 3, 32'h0,        1'b1};
        tbl[10] = '{1'b0, 32'h10,       32'h0,        0, 32'hDEADBEEF, 1'b0};
        tbl[11] = '{1'b0, 32'hFFFFFFFC, 32'h0,        0, 32'h0,        1'b1};

        rst = 1'b1;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;
        req_valid0 = 0; req_we0 = 0; req_addr0 = 0; req_wdata0 = 0; resp_ready0 = 0;
        #1;
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset rdata", resp_rdata, 32'd0);
        chk("reset err", {31'd0, resp_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int w = 0; w < 64; w++) model_txn(1'b1, 32'(w * 4), $urandom, 0, "fill");

        for (int i = 0; i < 12; i++)
            txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].hold,
                tbl[i].exp_rdata, tbl[i].exp_err, "table");

        // Full readback confirms the faulting stores touched nothing.
        for (int w = 0; w < 64; w++) model_txn(1'b0, 32'(w * 4), 32'd0, 0, "readback");

        for (int n = 0; n < 120; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, 63) * 4);
            else if (r == 7) a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            else if (r == 8) a = 32'(256 + $urandom_range(0, 1000) * 4);
            else             a = $urandom;
            model_txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), "rand");
        end

        // Strobes outside their states are ignored; captured request fields win.
        @(negedge clk);
        ref_mem[8] = 32'hA5A5A5A5;
        req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5; resp_ready = 1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            req_addr = 32'h24; req_wdata = 32'h0BADF00D;
        end while (!resp_valid && lat < 50);
        chk("ignore latency", 32'(lat), 32'd3);
        req_valid = 0;
        @(negedge clk);
        resp_ready = 0;
        chk("ignore one pulse", {31'd0, resp_valid}, 32'd0);
        chk("ignore back idle", {31'd0, req_ready}, 32'd1);
        $display("txn ignore store addr=00000020 lat=%0d", lat);
        model_txn(1'b0, 32'h20, 32'd0, 0, "ignore_chk20");
        model_txn(1'b0, 32'h24, 32'd0, 0, "ignore_chk24");

        // Reset during WAIT: store already committed, response dropped.
        model_txn(1'b0, 32'h13, 32'd0, 0, "pre_reset");
        @(negedge clk);
        ref_mem[1] = 32'h55AA00FF;
        req_valid = 1; req_we = 1; req_addr = 32'h4; req_wdata = 32'h55AA00FF; resp_ready = 0;
        @(negedge clk);
        req_valid = 0;
        chk("wait no valid", {31'd0, resp_valid}, 32'd0);
        chk("wait err kept", {31'd0, resp_err}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst wait ready", {31'd0, req_ready}, 32'd1);
        chk("rst wait valid", {31'd0, resp_valid}, 32'd0);
        chk("rst wait err", {31'd0, resp_err}, 32'd0);
        chk("rst wait rdata", resp_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post rst wait no valid", {31'd0, resp_valid}, 32'd0);
        end
        $display("txn reset_in_wait addr=00000004");
        txn(1'b0, 32'h4, 32'd0, 0, 32'h55AA00FF, 1'b0, "persist");

        // Reset while a response is held in RESP.
        er = model_rdata(1'b0, 32'hFC);
        @(negedge clk);
        req_valid = 1; req_we = 0; req_addr = 32'hFC; resp_ready = 0;
        lat = 0;
        do begin
            @(negedge clk);
            req_valid = 0;
            lat++;
        end while (!resp_valid && lat < 50);
        chk("resp latency", 32'(lat), 32'd3);
        chk("resp rdata", resp_rdata, er);
        #3 rst = 1'b1;
        #1;
        chk("rst resp valid", {31'd0, resp_valid}, 32'd0);
        chk("rst resp rdata", resp_rdata, 32'd0);
        chk("rst resp err", {31'd0, resp_err}, 32'd0);
        chk("rst resp ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post rst resp no valid", {31'd0, resp_valid}, 32'd0);
        end
        $display("txn reset_in_resp addr=000000fc");

        // Zero-wait instance: continuous requests accepted every other cycle.
        @(negedge clk);
        req_valid0 = 1; req_we0 = 1; req_addr0 = 32'h8; req_wdata0 = 32'h11111111; resp_ready0 = 1;
        chk("w0 k0 ready", {31'd0, req_ready0}, 32'd1);
        chk("w0 k0 valid", {31'd0, resp_valid0}, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("w0 valid", {31'd0, resp_valid0}, 32'(k % 2));
            chk("w0 ready", {31'd0, req_ready0}, 32'(1 - (k % 2)));
            $display("txn w0 cycle=%0d valid=%0d ready=%0d", k, resp_valid0, req_ready0);
        end
        req_we0 = 0;
        @(negedge clk);
        req_valid0 = 0;
        chk("w0 load valid", {31'd0, resp_valid0}, 32'd1);
        chk("w0 load rdata", resp_rdata0, 32'h11111111);
        chk("w0 load err", {31'd0, resp_err0}, 32'd0);
        @(negedge clk);
        chk("w0 load done", {31'd0, resp_valid0}, 32'd0);
        $display("txn w0 load addr=00000008 rdata=%h", resp_rdata0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, giving the number of 32-bit memory words (power of two, 4..1024).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving extra latency cycles per access (0..15).
REQ-003 The block SHALL have port clk  input  1  as the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  as the reset, asynchronous and active-high.
REQ-005 The block SHALL have port req_valid  input  1  as the core request strobe (load or store pending).
REQ-006 The block SHALL have port req_we  input  1  as the store select: 1 for store (MemWrite), 0 for load.
REQ-007 The block SHALL have port req_addr  input  32  as the byte address from the ALU result.
REQ-008 The block SHALL have port req_wdata  input  32  as the store data.
REQ-009 The block SHALL have port req_ready  output  1  as the request acceptance signal.
REQ-010 The block SHALL have port resp_valid  output  1  as the response-available signal.
REQ-011 The block SHALL have port resp_ready  input  1  as the core response acceptance signal.
REQ-012 The block SHALL have port resp_rdata  output  32  as the load data (0 for stores and errors).
REQ-013 The block SHALL have port resp_err  output  1  as the access fault flag, valid with resp_valid.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, RESP; req_ready = 1 only in IDLE, resp_valid = 1 only in RESP.
REQ-015 Accept: req_valid & req_ready at a clock edge; the block SHALL capture req_we, req_addr, req_wdata on that edge.
REQ-016 Fault: req_addr[1:0] != 0 or req_addr[31:2] >= DEPTH; fault SHALL be evaluated at accept and stored.
REQ-017 Store without fault SHALL write req_wdata to word req_addr[31:2] on the accept edge; a faulting store SHALL not modify memory.
REQ-018 IDLE -> WAIT on accept with counter loaded to WAIT_CYCLES when WAIT_CYCLES > 0; IDLE -> RESP on accept when WAIT_CYCLES = 0.
REQ-019 In WAIT the counter SHALL decrement each cycle; when it reaches 1 the FSM SHALL move to RESP on the next edge.
REQ-020 resp_valid SHALL first assert exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-021 On entry to RESP, resp_rdata SHALL be loaded with the addressed word for a non-faulting load, else 0; resp_err loaded with the stored fault.
REQ-022 resp_valid, resp_rdata, resp_err SHALL hold stable in RESP until resp_valid & resp_ready at an edge; then FSM -> IDLE.
REQ-023 After leaving RESP, resp_valid SHALL be 0 and resp_rdata/resp_err SHALL retain their last values until the next RESP entry.
REQ-024 A request SHALL not be accepted in the same cycle a response completes; minimum spacing between accepts is WAIT_CYCLES+2 cycles.
REQ-025 resp_ready asserted outside RESP and req_valid asserted outside IDLE SHALL be ignored.
REQ-026 A load to the word stored by the immediately preceding accepted store SHALL return the new data.

Reset
REQ-027 While rst = 1: state IDLE, counter 0, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, independent of clk.
REQ-028 Memory contents SHALL not be cleared by reset; a store completed on its accept edge before reset SHALL persist.
REQ-029 Reset during WAIT or RESP SHALL drop the pending response with no resp_valid pulse after rst deasserts.

Verification
REQ-030 WAIT_CYCLES=2: store addr 0x10 data 0xDEADBEEF, resp_ready=1 -> resp_valid high 3 cycles after accept, resp_err 0, resp_rdata 0; then load 0x10 -> resp_rdata 0xDEADBEEF.
REQ-031 Load addr 0x13 (misaligned) and load addr 0x100 with DEPTH=64 -> resp_err 1, resp_rdata 0; store to 0x100 leaves all words unchanged.
REQ-032 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata, resp_err constant; req_ready 0 throughout; completes on first resp_ready=1 edge.
REQ-033 WAIT_CYCLES=0: back-to-back req_valid held high with resp_ready=1 -> accepts every 2 cycles, resp_valid 1 cycle after each accept.
REQ-034 Assert rst mid-WAIT after store 0x55AA00FF to 0x4 -> outputs at reset values immediately, no resp_valid afterwards; later load 0x4 returns 0x55AA00FF.
REQ-035 Reset asserted between clock edges -> resp_valid and resp_err drop to 0 without waiting for a clk edge.
